// File: rtl/glcpu_pkg.sv
// Shared definitions for the ALU instruction sequencer.
// Holds the sequencer state enum, the register-file address width, the
// compare function code and the instruction field bit positions.
package glcpu_pkg;

  localparam int unsigned RF_AW = 2;

  // Compare sets flags only and never writes the register file.
  localparam logic [2:0] ALU_FUNC_CMP = 3'b110;

  // Instruction layout: {src_b[7:6], func[5:3], dst[2:1], unused[0]}.
  localparam int unsigned INSTR_SRC_B_MSB = 7;
  localparam int unsigned INSTR_SRC_B_LSB = 6;
  localparam int unsigned INSTR_FUNC_MSB  = 5;
  localparam int unsigned INSTR_FUNC_LSB  = 3;
  localparam int unsigned INSTR_DST_MSB   = 2;
  localparam int unsigned INSTR_DST_LSB   = 1;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StExec,
    StWb
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Decoder / register-file / ALU control bundle of the ALU sequencer.
// master: the sequencer (accepts instructions, drives datapath controls).
// slave:  the environment (decoder, register file, ALU).
// Signals: instr_valid/instr/instr_ready handshake, flush abort, register
// file read/write addresses and enables, ALU function and latch enables,
// done/busy status. alu_carry, alu_zero and flags exist only when the
// ALU_SEQ_FLAGS_EN macro is defined.
interface alu_sequencer_if #(
  parameter int unsigned RF_AW = 2
);
  logic             instr_valid;
  logic [7:0]       instr;
  logic             instr_ready;
  logic             flush;
  logic [RF_AW-1:0] rf_raddr;
  logic             a_load;
  logic             b_load;
  logic [2:0]       alu_func;
  logic             res_load;
  logic [RF_AW-1:0] rf_waddr;
  logic             rf_we;
  logic             done;
  logic             busy;
`ifdef ALU_SEQ_FLAGS_EN
  logic             alu_carry;
  logic             alu_zero;
  logic [1:0]       flags;
`endif

  modport master (
    input  instr_valid, instr, flush,
`ifdef ALU_SEQ_FLAGS_EN
    input  alu_carry, alu_zero,
    output flags,
`endif
    output instr_ready, rf_raddr, a_load, b_load, alu_func, res_load,
    output rf_waddr, rf_we, done, busy
  );

  modport slave (
    output instr_valid, instr, flush,
`ifdef ALU_SEQ_FLAGS_EN
    output alu_carry, alu_zero,
    input  flags,
`endif
    input  instr_ready, rf_raddr, a_load, b_load, alu_func, res_load,
    input  rf_waddr, rf_we, done, busy
  );

endinterface

// File: rtl/alu_seq_fsm.sv
// State register and next-state logic of the ALU sequencer.
// Ports: clk, reset (sync, active-high), flush (abort to idle),
// accept (instruction handshake this cycle), state (current state).
module alu_seq_fsm
  import glcpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       accept,
  output seq_state_e state
);

  seq_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = accept ? StRdA : StIdle;
        StRdA:   state_d = StRdB;
        StRdB:   state_d = StExec;
        StExec:  state_d = StWb;
        StWb:    state_d = accept ? StRdA : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller sequencing one register-to-register ALU instruction:
// read A, read B, execute, writeback. Accepts a new instruction in idle or in
// the writeback cycle.
// Ports: clk, reset (sync, active-high), bus (alu_sequencer_if.master).
// Optional feature macro: ALU_SEQ_FLAGS_EN adds a {carry, zero} flags register
// captured in execute and committed at the end of writeback.
module alu_sequencer #(
  parameter int unsigned RF_AW = glcpu_pkg::RF_AW
) (
  input logic            clk,
  input logic            reset,
  alu_sequencer_if.master bus
);
  import glcpu_pkg::*;

  seq_state_e state;
  logic       accept;
  logic [1:0] src_b_q;
  logic [1:0] dst_q;
  logic [2:0] func_q;

  // Ready is gated by flush so an aborting cycle never takes a new instruction.
  assign bus.instr_ready = ((state == StIdle) || (state == StWb)) && !bus.flush;
  assign accept          = bus.instr_valid && bus.instr_ready;

  alu_seq_fsm u_fsm (
    .clk    (clk),
    .reset  (reset),
    .flush  (bus.flush),
    .accept (accept),
    .state  (state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      src_b_q <= '0;
      dst_q   <= '0;
      func_q  <= '0;
    end else if (accept) begin
      src_b_q <= bus.instr[INSTR_SRC_B_MSB:INSTR_SRC_B_LSB];
      func_q  <= bus.instr[INSTR_FUNC_MSB:INSTR_FUNC_LSB];
      dst_q   <= bus.instr[INSTR_DST_MSB:INSTR_DST_LSB];
    end
  end

  logic unused_instr_lsb;
  assign unused_instr_lsb = bus.instr[0];

  always_comb begin
    bus.rf_raddr = '0;
    bus.a_load   = 1'b0;
    bus.b_load   = 1'b0;
    bus.alu_func = '0;
    bus.res_load = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_we    = 1'b0;
    bus.done     = 1'b0;
    bus.busy     = (state != StIdle);
    unique case (state)
      StRdA: begin
        bus.rf_raddr = RF_AW'(dst_q);
        bus.a_load   = 1'b1;
      end
      StRdB: begin
        bus.rf_raddr = RF_AW'(src_b_q);
        bus.b_load   = 1'b1;
      end
      StExec: begin
        bus.alu_func = func_q;
        bus.res_load = 1'b1;
      end
      StWb: begin
        bus.alu_func = func_q;
        bus.rf_waddr = RF_AW'(dst_q);
        // Flush retires nothing: no write, no done.
        bus.done     = !bus.flush;
        bus.rf_we    = !bus.flush && (func_q != ALU_FUNC_CMP);
      end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [1:0] flags_tmp_q;
  logic [1:0] flags_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_tmp_q <= '0;
      flags_q     <= '0;
    end else begin
      if (state == StExec) begin
        flags_tmp_q <= {bus.alu_carry, bus.alu_zero};
      end
      if ((state == StWb) && !bus.flush) begin
        flags_q <= flags_tmp_q;
      end
    end
  end

  assign bus.flags = flags_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios followed by
// randomized traffic, all compared against a cycle-count reference model.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_sequencer_if #(.RF_AW(2)) intf ();

  alu_sequencer #(.RF_AW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  // Reference model: an in-flight instruction and how many cycles ago it
  // was accepted (1..4). Cycle 4 is its writeback cycle.
  bit       m_have;
  int       m_age;
  bit [1:0] m_src_b;
  bit [2:0] m_func;
  bit [1:0] m_dst;
  bit [1:0] m_pend;
  bit [1:0] m_flags;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge: drive inputs, check outputs, advance model.
  task automatic step(input logic v, input logic [7:0] ins, input logic fl,
                      input logic rs, input logic c, input logic z);
    bit       e_ready;
    bit [1:0] e_raddr;
    bit [2:0] e_func;
    bit [1:0] e_waddr;
    bit       e_done;
    bit       e_we;
    intf.instr_valid = v;
    intf.instr       = ins;
    intf.flush       = fl;
    reset            = rs;
`ifdef ALU_SEQ_FLAGS_EN
    intf.alu_carry = c;
    intf.alu_zero  = z;
`endif
    #2;
    e_ready = (!m_have || m_age == 4) && !fl;
    e_raddr = !m_have ? 2'd0 : (m_age == 1) ? m_dst : (m_age == 2) ? m_src_b : 2'd0;
    e_func  = (m_have && m_age >= 3) ? m_func : 3'd0;
    e_waddr = (m_have && m_age == 4) ? m_dst : 2'd0;
    e_done  = m_have && m_age == 4 && !fl;
    e_we    = e_done && (m_func != 3'b110);
    check("instr_ready", 8'(intf.instr_ready), 8'(e_ready));
    check("busy", 8'(intf.busy), 8'(m_have));
    check("rf_raddr", 8'(intf.rf_raddr), 8'(e_raddr));
    check("a_load", 8'(intf.a_load), 8'(m_have && m_age == 1));
    check("b_load", 8'(intf.b_load), 8'(m_have && m_age == 2));
    check("alu_func", 8'(intf.alu_func), 8'(e_func));
    check("res_load", 8'(intf.res_load), 8'(m_have && m_age == 3));
    check("rf_waddr", 8'(intf.rf_waddr), 8'(e_waddr));
    check("done", 8'(intf.done), 8'(e_done));
    check("rf_we", 8'(intf.rf_we), 8'(e_we));
`ifdef ALU_SEQ_FLAGS_EN
    check("flags", 8'(intf.flags), 8'(m_flags));
`endif
    // State update at the coming edge.
    if (rs) begin
      m_have = 0; m_age = 0; m_pend = 0; m_flags = 0;
    end else if (fl) begin
      m_have = 0;
    end else begin
      if (m_have && m_age == 3) m_pend = {c, z};
      if (m_have && m_age == 4) m_flags = m_pend;
      if (e_ready && v) begin
        m_have  = 1;
        m_age   = 1;
        m_src_b = ins[7:6];
        m_func  = ins[5:3];
        m_dst   = ins[2:1];
      end else if (m_have) begin
        if (m_age == 4) m_have = 0;
        else m_age++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, 0);
  endtask

  initial begin
    reset            = 1'b1;
    intf.instr_valid = 1'b0;
    intf.instr       = 8'h00;
    intf.flush       = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
    intf.alu_carry = 1'b0;
    intf.alu_zero  = 1'b0;
`endif
    m_have = 0; m_age = 0; m_pend = 0; m_flags = 0;
    m_src_b = 0; m_func = 0; m_dst = 0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset values, then idle.
    idle(10);

    // Single operation: src_b=2, func=3, dst=1.
    step(1, 8'b10_011_01_0, 0, 0, 0, 0);
    idle(5);

    // Back-to-back: second instruction valid from cycle 1, taken in WB.
    step(1, 8'b01_001_10_0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 8'b11_100_11_0, 0, 0, 1, 0);
    idle(6);

    // Compare with zero set: no write, flags {0,1}.
    step(1, 8'b01_110_10_0, 0, 0, 0, 0);
    idle(2);
    step(0, 8'h00, 0, 0, 0, 1);
    idle(3);

    // Flush in WB after a carry-setting execute: nothing retires.
    step(1, 8'b00_010_11_0, 0, 0, 0, 0);
    idle(2);
    step(0, 8'h00, 0, 0, 1, 0);
    step(1, 8'b00_000_01_0, 1, 0, 0, 0);
    idle(3);

    // Flush in RD_B.
    step(1, 8'b10_101_00_0, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0, 0);
    idle(3);

    // Reset in EXEC.
    step(1, 8'b11_111_11_0, 0, 0, 0, 0);
    idle(2);
    step(0, 8'h00, 0, 1, 1, 1);
    idle(5);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) == 0, 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
